// File: rtl/pc_seq_if.sv
// Bundle of decode/execute-side signals exchanged with pc_sequencer.
// master = decode/execute + PC side, slave = the sequencer.
interface pc_seq_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] pc;
    logic              stall;
    logic              halt;
    logic              resume;
    logic              br_req;
    logic [ADDR_W-1:0] br_target;
    logic              j_req;
    logic              j_link;
    logic [ADDR_W-1:0] j_target;
    logic              jr_req;
    logic [ADDR_W-1:0] jr_target;
    logic [1:0]        pc_op;
    logic [ADDR_W-1:0] pc_target;
    logic              redir_ack;
    logic              flush;
    logic              align_err;
    logic              link_we;
    logic [ADDR_W-1:0] link_addr;
    logic [31:0]       fetch_count;

    modport master (
        output pc, stall, halt, resume,
               br_req, br_target, j_req, j_link, j_target, jr_req, jr_target,
        input  pc_op, pc_target, redir_ack, flush, align_err,
               link_we, link_addr, fetch_count
    );

    modport slave (
        input  pc, stall, halt, resume,
               br_req, br_target, j_req, j_link, j_target, jr_req, jr_target,
        output pc_op, pc_target, redir_ack, flush, align_err,
               link_we, link_addr, fetch_count
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: post-reset clear, redirect arbitration, stall and halt control.
// Define PC_SEQ_DELAY_SLOT_EN for a MIPS-style branch delay slot (DSLOT state, link = pc + 8).
module pc_sequencer #(
    parameter int ADDR_W       = 32,
    parameter int RESET_CYCLES = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    pc_seq_if.slave   bus
);

    localparam logic [1:0] OP_INC   = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_HOLD  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    localparam logic [1:0] ST_INIT  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_HALT  = 2'd2;
`ifdef PC_SEQ_DELAY_SLOT_EN
    localparam logic [1:0] ST_DSLOT = 2'd3;
    localparam logic [ADDR_W-1:0] LINK_OFF = ADDR_W'(8);
`else
    localparam logic [ADDR_W-1:0] LINK_OFF = ADDR_W'(4);
`endif

    localparam int CNT_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RESET_CYCLES - 1);

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       fetch_count_q, fetch_count_d;
`ifdef PC_SEQ_DELAY_SLOT_EN
    logic [ADDR_W-1:0] dslot_target_q, dslot_target_d;
`endif

    logic [1:0]        pc_op;
    logic [ADDR_W-1:0] load_target;
    logic              accept;
    logic              any_req;
    logic              sel_is_jal;
    logic [ADDR_W-1:0] sel_target;
    logic [ADDR_W-1:0] sel_target_aligned;

    // Fixed-priority source select; only meaningful when a redirect is accepted.
    always_comb begin
        sel_target = bus.br_target;
        sel_is_jal = 1'b0;
        if (bus.jr_req) begin
            sel_target = bus.jr_target;
        end else if (bus.j_req) begin
            sel_target = bus.j_target;
            sel_is_jal = bus.j_link;
        end
    end

    assign any_req            = bus.jr_req | bus.j_req | bus.br_req;
    assign sel_target_aligned = {sel_target[ADDR_W-1:2], 2'b00};

    // NOTE: every variable written here gets a default first, so no path leaves one unassigned and infers a latch.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        pc_op         = OP_HOLD;
        load_target   = '0;
        accept        = 1'b0;
`ifdef PC_SEQ_DELAY_SLOT_EN
        dslot_target_d = dslot_target_q;
`endif

        case (state_q)
            ST_INIT: begin
                pc_op = OP_CLEAR;
                if (cnt_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            ST_RUN: begin
                if (bus.halt) begin
                    pc_op   = OP_HOLD;
                    state_d = ST_HALT;
                end else if (bus.stall) begin
                    pc_op = OP_HOLD;
                end else if (any_req) begin
                    accept = 1'b1;
`ifdef PC_SEQ_DELAY_SLOT_EN
                    // Fetch the delay-slot instruction now, load the target next cycle.
                    pc_op          = OP_INC;
                    dslot_target_d = sel_target_aligned;
                    state_d        = ST_DSLOT;
`else
                    pc_op       = OP_LOAD;
                    load_target = sel_target_aligned;
`endif
                end else begin
                    pc_op = OP_INC;
                end
            end

            ST_HALT: begin
                pc_op = OP_HOLD;
                if (bus.resume && !bus.halt) begin
                    state_d = ST_RUN;
                end
            end

`ifdef PC_SEQ_DELAY_SLOT_EN
            ST_DSLOT: begin
                // Halt is deferred until the latched load has completed.
                if (bus.stall) begin
                    pc_op = OP_HOLD;
                end else begin
                    pc_op       = OP_LOAD;
                    load_target = dslot_target_q;
                    state_d     = ST_RUN;
                end
            end
`endif

            default: begin
                pc_op   = OP_CLEAR;
                state_d = ST_INIT;
            end
        endcase
    end

    assign fetch_count_d = (pc_op == OP_INC || pc_op == OP_LOAD)
                         ? fetch_count_q + 32'd1
                         : fetch_count_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_INIT;
            cnt_q         <= CNT_INIT;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            fetch_count_q <= fetch_count_d;
        end
    end

`ifdef PC_SEQ_DELAY_SLOT_EN
    // NOTE: the target latch is reset so a reset taken in DSLOT cannot leak a stale target later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dslot_target_q <= '0;
        end else begin
            dslot_target_q <= dslot_target_d;
        end
    end
`endif

    assign bus.pc_op       = pc_op;
    assign bus.pc_target   = load_target;
    assign bus.redir_ack   = accept;
`ifdef PC_SEQ_DELAY_SLOT_EN
    assign bus.flush       = 1'b0;
`else
    assign bus.flush       = accept;
`endif
    assign bus.align_err   = accept & (sel_target[1:0] != 2'b00);
    assign bus.link_we     = accept & sel_is_jal;
    assign bus.link_addr   = bus.pc + LINK_OFF;
    assign bus.fetch_count = fetch_count_q;

endmodule
